// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  // Access size codes, taken from instruction bits [27:26]
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b11;

  // Load/store opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam int DEF_TIMEOUT = 16;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    is_aligned = 1'b1;
      SZ_H:    is_aligned = ~off[0];
      default: is_aligned = (off == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store enables/data generation and load select/extension.
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wdata,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_off,
  input  logic        i_ld_zext,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Replicating the data lets the byte enables alone pick the destination lane
  always_comb begin
    o_st_be    = 4'b1111;
    o_st_wdata = i_st_data;
    case (i_st_size)
      SZ_B: begin
        o_st_be    = 4'b0001 << i_st_off;
        o_st_wdata = {4{i_st_data[7:0]}};
      end
      SZ_H: begin
        o_st_be    = i_st_off[1] ? 4'b1100 : 4'b0011;
        o_st_wdata = {2{i_st_data[15:0]}};
      end
      default: begin
        o_st_be    = 4'b1111;
        o_st_wdata = i_st_data;
      end
    endcase
  end

  always_comb begin
    w_byte = i_ld_rdata[7:0];
    case (i_ld_off)
      2'd0:    w_byte = i_ld_rdata[7:0];
      2'd1:    w_byte = i_ld_rdata[15:8];
      2'd2:    w_byte = i_ld_rdata[23:16];
      default: w_byte = i_ld_rdata[31:24];
    endcase
    w_half = i_ld_off[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
  end

  always_comb begin
    o_ld_data = i_ld_rdata;
    case (i_ld_size)
      SZ_B:    o_ld_data = {{24{~i_ld_zext & w_byte[7]}}, w_byte};
      SZ_H:    o_ld_data = {{16{~i_ld_zext & w_half[15]}}, w_half};
      default: o_ld_data = i_ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: IDLE/BUSY/DONE handshake to a data bus with ack timeout.
// Optional MISALIGN_CHECK_EN adds mem_misalign and suppresses misaligned accesses.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_inst,
  input  logic [31:0] mem_ALUOUT,
  input  logic [31:0] mem_WriteData,
  input  logic        mem_MemRead,
  input  logic        mem_MemWrite,
  input  logic [4:0]  mem_RegisterRd,
  input  logic        mem_RegDst,
  input  logic        mem_MemtoReg,
  input  logic        mem_RegWrite,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_MEMOUT,
  output logic        mem_RegWrite_o,
  output logic        mem_stall,
  output logic        mem_bus_err,
  output logic [4:0]  mem_RegisterRd_o,
  output logic        mem_RegDst_o,
  output logic        mem_MemtoReg_o
`ifdef MISALIGN_CHECK_EN
  ,
  output logic        mem_misalign
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_e       r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr, r_wdata, r_result;
  logic [3:0]       r_be;
  logic             r_we, r_bus_err, r_zext;
  logic [1:0]       r_size, r_off;

  logic [1:0]  w_size;
  logic        w_access, w_aligned, w_misalign, w_start, w_timeout, w_finish;
  logic        w_stall, w_req;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata, w_ld_data;
  logic        w_unused_inst;

  assign w_size        = mem_inst[27:26];
  assign w_access      = mem_MemRead | mem_MemWrite;
  assign w_unused_inst = ^{mem_inst[31:29], mem_inst[25:0]};

`ifdef MISALIGN_CHECK_EN
  assign w_aligned    = is_aligned(w_size, mem_ALUOUT[1:0]);
  assign mem_misalign = w_misalign;
`else
  assign w_aligned = 1'b1;
`endif

  assign w_misalign = (r_state == IDLE) & w_access & ~w_aligned;
  assign w_start    = (r_state == IDLE) & w_access & w_aligned;
  // An ack arriving in the final counted cycle wins over the timeout
  assign w_timeout  = (r_state == BUSY) & ~dmem_ack & (r_cnt == CNT_LAST);
  assign w_finish   = (r_state == BUSY) & (dmem_ack | w_timeout);

  mem_align u_align (
    .i_st_size  (w_size),
    .i_st_off   (mem_ALUOUT[1:0]),
    .i_st_data  (mem_WriteData),
    .o_st_be    (w_st_be),
    .o_st_wdata (w_st_wdata),
    .i_ld_size  (r_size),
    .i_ld_off   (r_off),
    .i_ld_zext  (r_zext),
    .i_ld_rdata (dmem_rdata),
    .o_ld_data  (w_ld_data)
  );

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_req        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_next = BUSY;
          w_stall      = 1'b1;
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        w_req   = 1'b1;
        if (w_finish) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_we      <= 1'b0;
      r_result  <= '0;
      r_bus_err <= 1'b0;
      r_size    <= SZ_W;
      r_off     <= 2'b00;
      r_zext    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bus_err <= w_timeout;
      if (w_start) begin
        r_addr  <= {mem_ALUOUT[31:2], 2'b00};
        r_wdata <= w_st_wdata;
        r_be    <= w_st_be;
        r_we    <= mem_MemWrite;
        r_size  <= w_size;
        r_off   <= mem_ALUOUT[1:0];
        r_zext  <= mem_inst[28];
      end
      if (r_state == BUSY) begin
        if (w_finish) begin
          r_cnt <= '0;
          r_we  <= 1'b0;
        end else if (r_cnt != CNT_LAST) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if ((r_state == BUSY) && dmem_ack) begin
        r_result <= r_we ? 32'h0 : w_ld_data;
      end else if (w_timeout) begin
        r_result <= 32'h0;
      end
    end
  end

  assign dmem_req         = w_req;
  assign dmem_we          = r_we;
  assign dmem_addr        = r_addr;
  assign dmem_wdata       = r_wdata;
  assign dmem_be          = r_be;
  assign mem_stall        = w_stall;
  assign mem_bus_err      = r_bus_err;
  assign mem_MEMOUT       = (r_state == DONE) ? r_result : 32'h0;
  assign mem_RegWrite_o   = mem_RegWrite & ~((r_state == DONE) & r_bus_err) & ~w_misalign;
  assign mem_RegisterRd_o = mem_RegisterRd;
  assign mem_RegDst_o     = mem_RegDst;
  assign mem_MemtoReg_o   = mem_MemtoReg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a scoreboard of expected DONE-cycle results.
`timescale 1ns/1ps
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_inst, mem_ALUOUT, mem_WriteData;
  logic        mem_MemRead, mem_MemWrite, mem_RegDst, mem_MemtoReg, mem_RegWrite;
  logic [4:0]  mem_RegisterRd;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [31:0] mem_MEMOUT;
  logic        mem_RegWrite_o, mem_stall, mem_bus_err, mem_RegDst_o, mem_MemtoReg_o;
  logic [4:0]  mem_RegisterRd_o;
`ifdef MISALIGN_CHECK_EN
  logic        mem_misalign;
`endif

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .mem_inst(mem_inst), .mem_ALUOUT(mem_ALUOUT), .mem_WriteData(mem_WriteData),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_RegisterRd(mem_RegisterRd), .mem_RegDst(mem_RegDst),
    .mem_MemtoReg(mem_MemtoReg), .mem_RegWrite(mem_RegWrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_MEMOUT(mem_MEMOUT),
    .mem_RegWrite_o(mem_RegWrite_o), .mem_stall(mem_stall),
    .mem_bus_err(mem_bus_err), .mem_RegisterRd_o(mem_RegisterRd_o),
    .mem_RegDst_o(mem_RegDst_o), .mem_MemtoReg_o(mem_MemtoReg_o)
`ifdef MISALIGN_CHECK_EN
    , .mem_misalign(mem_misalign)
`endif
  );

  typedef struct {
    logic [31:0] memout;
    logic        regw;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_inst       = 32'h0;
    mem_ALUOUT     = 32'h0;
    mem_WriteData  = 32'h0;
    mem_MemRead    = 1'b0;
    mem_MemWrite   = 1'b0;
    mem_RegisterRd = 5'd0;
    mem_RegDst     = 1'b0;
    mem_MemtoReg   = 1'b0;
    mem_RegWrite   = 1'b0;
  endtask

  task automatic present(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd);
    mem_inst       = {op, 26'h0};
    mem_ALUOUT     = addr;
    mem_WriteData  = wd;
    mem_MemRead    = (op[5:3] == 3'b100);
    mem_MemWrite   = (op[5:3] == 3'b101);
    mem_RegisterRd = 5'd9;
    mem_RegDst     = 1'b0;
    mem_MemtoReg   = (op[5:3] == 3'b100);
    mem_RegWrite   = (op[5:3] == 3'b100);
  endtask

  // ack_at = BUSY cycle carrying the ack (0 = never)
  task automatic run_access(input string tag, input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] wd, input int ack_at, input logic [31:0] rdata,
                            input logic [31:0] exp_out, input int exp_stall, input logic exp_err,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
    exp_t e;
    logic is_store;
    int   stall_n;
    bit   done;
    is_store = (op[5:3] == 3'b101);
    e.memout = exp_out;
    e.regw   = ~is_store & ~exp_err;
    e.err    = exp_err;
    sb_q.push_back(e);

    @(posedge clk); #1;
    present(op, addr, wd);
    dmem_ack = 1'b0;
    @(negedge clk);
    check({tag, "_idle_stall"}, mem_stall, 1);
    check({tag, "_idle_req"}, dmem_req, 0);
    stall_n = 1;
    done    = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk); #1;
      dmem_ack   = (c == ack_at);
      dmem_rdata = (c == ack_at) ? rdata : 32'h5555_5555;
      @(negedge clk);
      if (mem_stall) begin
        stall_n++;
        check({tag, "_busy_req"}, dmem_req, 1);
        check({tag, "_busy_addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
        check({tag, "_busy_we"}, dmem_we, is_store);
        if (c == 1 && is_store) begin
          check({tag, "_be"}, dmem_be, exp_be);
          check({tag, "_wdata"}, dmem_wdata, exp_wd);
        end
      end else begin
        done = 1;
        e = sb_q.pop_front();
        check({tag, "_memout"}, mem_MEMOUT, e.memout);
        check({tag, "_regwrite"}, mem_RegWrite_o, e.regw);
        check({tag, "_bus_err"}, mem_bus_err, e.err);
        check({tag, "_done_req"}, dmem_req, 0);
      end
    end
    if (!done) begin
      check({tag, "_completion"}, 0, 1);
      void'(sb_q.pop_front());
    end
    check({tag, "_stall_cycles"}, stall_n, exp_stall);
    @(posedge clk); #1;
    idle_inputs();
    dmem_ack = 1'b0;
    @(negedge clk);
    check({tag, "_err_after"}, mem_bus_err, 0);
    check({tag, "_stall_after"}, mem_stall, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    rst        = 1'b0;

    @(negedge clk);
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_be", dmem_be, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_memout", mem_MEMOUT, 0);
    check("rst_bus_err", mem_bus_err, 0);
    check("rst_stall", mem_stall, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Non-memory instruction: pass-through, no stall
    @(posedge clk); #1;
    mem_inst       = 32'h0000_0020;
    mem_RegWrite   = 1'b1;
    mem_RegDst     = 1'b1;
    mem_RegisterRd = 5'd7;
    @(negedge clk);
    check("alu_stall", mem_stall, 0);
    check("alu_memout", mem_MEMOUT, 0);
    check("alu_regwrite", mem_RegWrite_o, 1);
    check("alu_rd", mem_RegisterRd_o, 7);
    check("alu_regdst", mem_RegDst_o, 1);
    check("alu_req", dmem_req, 0);
    @(posedge clk); #1;
    idle_inputs();

    run_access("lw", OP_LW, 32'h100, 32'h0, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3, 1'b0, 4'b1111, 32'h0);
    run_access("lb", OP_LB, 32'h103, 32'h0, 1, 32'h80FF_1234, 32'hFFFF_FF80, 2, 1'b0, 4'b1000, 32'h0);
    run_access("lbu", OP_LBU, 32'h103, 32'h0, 1, 32'h80FF_1234, 32'h0000_0080, 2, 1'b0, 4'b1000, 32'h0);
    run_access("lh", OP_LH, 32'h102, 32'h0, 1, 32'h8001_1234, 32'hFFFF_8001, 2, 1'b0, 4'b1100, 32'h0);
    run_access("lhu", OP_LHU, 32'h100, 32'h0, 2, 32'h1234_F00D, 32'h0000_F00D, 3, 1'b0, 4'b0011, 32'h0);
    run_access("sh", OP_SH, 32'h102, 32'h0000_ABCD, 3, 32'h0, 32'h0, 4, 1'b0, 4'b1100, 32'hABCD_ABCD);
    run_access("sb", OP_SB, 32'h101, 32'h0000_005A, 1, 32'h0, 32'h0, 2, 1'b0, 4'b0010, 32'h5A5A_5A5A);
    run_access("sw", OP_SW, 32'h10C, 32'h1234_5678, 1, 32'h0, 32'h0, 2, 1'b0, 4'b1111, 32'h1234_5678);
    run_access("timeout", OP_LW, 32'h200, 32'h0, 0, 32'h0, 32'h0, 17, 1'b1, 4'b1111, 32'h0);
    run_access("ack_at_limit", OP_LW, 32'h204, 32'h0, 16, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 17, 1'b0, 4'b1111, 32'h0);

    // Asynchronous reset while BUSY
    @(posedge clk); #1;
    present(OP_LW, 32'h300, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstbusy_req_before", dmem_req, 1);
    #2;
    rst = 1'b0;
    #1;
    check("rstbusy_req", dmem_req, 0);
    check("rstbusy_addr", dmem_addr, 0);
    check("rstbusy_memout", mem_MEMOUT, 0);
    check("rstbusy_idle_stall", mem_stall, 1);
    idle_inputs();
    #1;
    check("rstbusy_stall_cleared", mem_stall, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_access("lw_after_rst", OP_LW, 32'h104, 32'h0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 2, 1'b0, 4'b1111, 32'h0);

`ifdef MISALIGN_CHECK_EN
    @(posedge clk); #1;
    present(OP_LW, 32'h102, 32'h0);
    @(negedge clk);
    check("mis_flag", mem_misalign, 1);
    check("mis_req", dmem_req, 0);
    check("mis_stall", mem_stall, 0);
    check("mis_regwrite", mem_RegWrite_o, 0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("mis_flag_after", mem_misalign, 0);
    check("mis_req_after", dmem_req, 0);
`else
    run_access("lw_unaligned", OP_LW, 32'h102, 32'h0, 1, 32'h1122_3344, 32'h1122_3344, 2, 1'b0, 4'b1111, 32'h0);
`endif

    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
